brent_kung_pipe_adder: RTL and testbench
========================================

Name: brent_kung_pipe_adder

Overview:
- Parametrised, pipelined successor to the fixed 32-bit combinational Brent-Kung adder.
- Computes a+b+cin or a-b with a WIDTH-bit Brent-Kung prefix tree split into PIPE_STAGES register stages.
- Adds a valid/ready handshake with backpressure and signed-overflow reporting.
- Sits between operand producers and the datapath consumer that previously used the combinational adder.

Parameters:
- WIDTH, 32, operand width; must be a power of 2 and at least 4.
- PIPE_STAGES, 2, number of register stages from input accept to output. Legal range is 1 to L, where L = 2*clog2(WIDTH)-1 prefix levels.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 selects a+b+cin; 1 selects a-b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out of MSB. For sub=1, this is 1 when there is no borrow (a>=b unsigned).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Only clock is clk. rst is synchronous and active-high.
- While rst=1 at a clk edge, all stage valids, out_valid, sum, cout and ovf clear to 0. Data registers may also clear.
- in_ready=0 whenever rst=1.
- Reset mid-operation discards all in-flight beats; none appear after reset.
- Subtract path: when sub=1, the effective b is ~b and the effective carry-in is 1. The cin input is ignored.
- Generate/propagate: g=a&b_eff, p=a^b_eff. Carry-in folds in at bit 0 as g0'=g0|(p0&cin_eff).
- Prefix tree: L levels, with an up-sweep followed by a down-sweep. Operator is (G,P)o(G',P') = (G|P&G', P&P').
- Outputs: sum = p ^ {carries[WIDTH-2:0], cin_eff}. cout = carry[WIDTH-1].
- Overflow: ovf = carry into MSB XOR carry out of MSB.
- Pipeline register placement: registers sit after prefix levels floor(k*L/PIPE_STAGES) for k=1..PIPE_STAGES-1. A final output register holds sum/cout/ovf/out_valid.
- PIPE_STAGES=1 means the output register only.
- Latency: a beat accepted at edge n (in_valid & in_ready) presents out_valid=1 and its result after edge n+PIPE_STAGES-1, assuming no stall.
- Global advance enable: en = !out_valid | out_ready.
- in_ready = en & !rst, and is purely combinational from out_valid, out_ready and rst.
- When en=0, every stage register, including bubbles, holds its value.
- When en=1, every stage shifts by one. A stage receives valid=0 if no beat was accepted.
- Throughput: one beat per cycle while out_ready=1.
- out_valid with result fields stays stable until out_ready=1 (AXI-style hold).
- Accept and output on the same edge is permitted; the pipeline stays full.
- Ordering: results leave in acceptance order. There is no drop and no duplication.
- Mode is per-beat: sub and cin travel with the beat through the stages.
- Wrap-around: sum is truncated to WIDTH bits. Overflow information is carried only on cout/ovf.

Test Plan:
- WIDTH=32, PIPE_STAGES=2, out_ready=1. Stream a=1024, b=1023, cin=0, then a=0xFFFFFFFF, b=1, cin=0 -> first result sum=2047, cout=0, ovf=0 one edge after accept; next cycle sum=0, cout=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, ovf=1, cout=0. Then a=0, b=1, sub=1 -> sum=0xFFFFFFFF, cout=0 (borrow), ovf=0. Then a=5, b=5, sub=1 -> sum=0, cout=1.
- Backpressure: fill with 3 beats (values 1+1, 2+2, 3+3), hold out_ready=0 for 4 cycles -> out_valid=1, sum=2 held stable, in_ready=0. Release -> sum 2, 4, 6 on consecutive cycles with no loss.
- Reset mid-flight: two beats in flight, assert rst for one edge -> out_valid=0, sum=0, cout=0, ovf=0 next cycle. Neither beat ever emerges, and in_ready=0 during rst.
- Parameter sweep: WIDTH in {4,8,16,64}, PIPE_STAGES in {1, L}. Exhaustive for WIDTH=4 (all a, b, cin, sub); random 10^5 beats otherwise with random in_valid/out_ready -> every result matches the reference model (a+b+cin or a-b, mod 2^WIDTH, cout, ovf), in order. Latency equals PIPE_STAGES when unstalled.
- cin ignored in subtract: a=10, b=3, sub=1, cin=1 -> sum=7, cout=1.

Source files
------------

// File: rtl/brent_kung_pipe_adder_if.sv
// Operand/result bundle for brent_kung_pipe_adder: input beat channel plus result channel.
// Latency: none, wires only.
// Backpressure: in_ready throttles the producer, out_ready throttles the adder.
interface brent_kung_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/brent_kung_pipe_adder.sv
// Pipelined Brent-Kung adder/subtractor: a+b+cin or a-b, with carry-out and signed overflow.
// Latency: PIPE_STAGES register stages from accept edge to registered result (1 = output reg only).
// Backpressure: a single advance enable stalls every stage while a result waits for out_ready.
module brent_kung_pipe_adder #(
  parameter int WIDTH       = 32,  // power of two, >= 4
  parameter int PIPE_STAGES = 2    // 1 .. 2*clog2(WIDTH)-1
) (
  input  logic                   clk,
  input  logic                   rst,
  brent_kung_pipe_adder_if.slave bus
);

  localparam int LOG    = $clog2(WIDTH);
  localparam int LEVELS = 2 * LOG - 1;

  // Everything one beat needs while it walks the prefix tree. prop is the
  // untouched bitwise propagate used for the final sum; grp_g/grp_p are the
  // group terms the tree keeps refining.
  typedef struct packed {
    logic             vld;
    logic             cin_eff;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] grp_g;
    logic [WIDTH-1:0] grp_p;
  } stage_t;

  // Bit j set means a register sits after prefix level j. The cut points are
  // spread as evenly as integer division allows; level 0 is never cut, so a
  // cut always has at least one level of logic in front of it.
  function automatic logic [LEVELS-1:0] cut_mask();
    logic [LEVELS-1:0] m;
    m = '0;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      m[(k * LEVELS) / PIPE_STAGES] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [LEVELS-1:0] CUT = cut_mask();

  // One level of the Brent-Kung tree. Levels 1..LOG are the up-sweep
  // (span doubles), levels LOG+1..LEVELS are the down-sweep (span halves,
  // filling in the odd positions the up-sweep skipped).
  function automatic stage_t prefix_level(input stage_t s, input int lvl);
    stage_t r;
    int     d;
    int     j;
    r = s;
    if (lvl <= LOG) begin
      d = 1 << (lvl - 1);
      for (int i = 0; i < WIDTH; i++) begin
        j = (i >= d) ? i - d : 0;
        if (((i + 1) % (2 * d)) == 0) begin
          r.grp_g[i] = s.grp_g[i] | (s.grp_p[i] & s.grp_g[j]);
          r.grp_p[i] = s.grp_p[i] & s.grp_p[j];
        end
      end
    end else begin
      d = 1 << (2 * LOG - 1 - lvl);
      for (int i = 0; i < WIDTH; i++) begin
        j = (i >= d) ? i - d : 0;
        if ((((i + 1) % (2 * d)) == d) && (i >= 3 * d - 1)) begin
          r.grp_g[i] = s.grp_g[i] | (s.grp_p[i] & s.grp_g[j]);
          r.grp_p[i] = s.grp_p[i] & s.grp_p[j];
        end
      end
    end
    return r;
  endfunction

  logic             en;
  stage_t           tap    [LEVELS];
  stage_t           pipe_q [LEVELS];
  logic             vld_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // Whole pipeline moves together; it only freezes while a result is parked.
  assign en           = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = en & ~rst;

  // Build level-0 terms, then walk the tree, swapping in the registered copy
  // wherever a cut sits, and form the result from the final carries.
  always_comb begin
    stage_t           cur;
    logic [WIDTH-1:0] b_eff;
    b_eff         = bus.sub ? ~bus.b : bus.b;
    cur.vld       = bus.in_valid & bus.in_ready;
    cur.cin_eff   = bus.sub | bus.cin;
    cur.prop      = bus.a ^ b_eff;
    cur.grp_p     = cur.prop;
    cur.grp_g     = bus.a & b_eff;
    cur.grp_g[0]  = cur.grp_g[0] | (cur.prop[0] & cur.cin_eff);
    for (int j = 0; j < LEVELS; j++) begin
      tap[j] = cur;
      if (CUT[j]) begin
        cur = pipe_q[j];
      end
      cur = prefix_level(cur, j + 1);
    end
    // grp_g[i] is now the carry out of bit i.
    vld_d  = cur.vld;
    sum_d  = cur.prop ^ {cur.grp_g[WIDTH-2:0], cur.cin_eff};
    cout_d = cur.grp_g[WIDTH-1];
    ovf_d  = cur.grp_g[WIDTH-1] ^ cur.grp_g[WIDTH-2];
  end

  // Intermediate prefix registers at the cut boundaries; bubbles shift like beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < LEVELS; j++) begin
        pipe_q[j] <= '0;
      end
    end else if (en) begin
      for (int j = 0; j < LEVELS; j++) begin
        if (CUT[j]) begin
          pipe_q[j] <= tap[j];
        end
      end
    end
  end

  // Output register; held while out_ready is low so the result stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= vld_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_brent_kung_pipe_adder.sv
// Directed and model-checked bench for brent_kung_pipe_adder.
// Main instance: WIDTH=32/PIPE_STAGES=2; sweep instances: WIDTH=4/PIPE_STAGES=3, WIDTH=8/PIPE_STAGES=1.
// Covers reset, add/sub results, overflow, stall hold, reset flush, ordering under random backpressure.
module tb_brent_kung_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  brent_kung_pipe_adder_if #(.WIDTH(32)) bus32 ();
  brent_kung_pipe_adder_if #(.WIDTH(4))  bus4 ();
  brent_kung_pipe_adder_if #(.WIDTH(8))  bus8 ();

  brent_kung_pipe_adder #(.WIDTH(32), .PIPE_STAGES(2)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  brent_kung_pipe_adder #(.WIDTH(4),  .PIPE_STAGES(3)) dut4  (.clk(clk), .rst(rst), .bus(bus4));
  brent_kung_pipe_adder #(.WIDTH(8),  .PIPE_STAGES(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                         input logic c, input logic s);
    bus32.in_valid = v;
    bus32.a        = aa;
    bus32.b        = bb;
    bus32.cin      = c;
    bus32.sub      = s;
  endtask

  task automatic settle32();
    drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus32.out_ready = 1'b1;
    repeat (3) cyc();
  endtask

  // Plain arithmetic reference: returns {ovf, cout, sum[63:0]}.
  function automatic logic [65:0] model(input int w, input logic [63:0] aa, input logic [63:0] bb,
                                        input logic c, input logic s);
    logic [64:0] full;
    logic [63:0] mask;
    logic [63:0] bm;
    logic [63:0] sm;
    logic        co;
    logic        ov;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    bm   = s ? (~bb & mask) : bb;
    full = {1'b0, aa} + {1'b0, bm} + {64'd0, (s ? 1'b1 : c)};
    sm   = full[63:0] & mask;
    co   = full[w];
    if (s) ov = (aa[w-1] != bb[w-1]) && (sm[w-1] != aa[w-1]);
    else   ov = (aa[w-1] == bb[w-1]) && (sm[w-1] != aa[w-1]);
    return {ov, co, sm};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive32(1'b1, 32'd5, 32'd6, 1'b0, 1'b0);
    cyc();
    cyc();
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus32.out_valid); end
    checks++; if (bus32.sum !== 32'd0) begin errors++; $display("FAIL rst_sum: got %h want 0", bus32.sum); end
    checks++; if ({bus32.cout, bus32.ovf} !== 2'b00) begin errors++; $display("FAIL rst_cout_ovf: got %b want 00", {bus32.cout, bus32.ovf}); end
    checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus32.in_ready); end
    checks++; if ({bus4.out_valid, bus8.out_valid} !== 2'b00) begin errors++; $display("FAIL rst_sweep_valid: got %b want 00", {bus4.out_valid, bus8.out_valid}); end
    rst = 1'b0;
    drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", bus32.in_ready); end
  endtask

  task automatic test_add_stream();
    bus32.out_ready = 1'b1;
    drive32(1'b1, 32'd1024, 32'd1023, 1'b0, 1'b0);
    cyc();
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL add_latency_early: got %b want 0", bus32.out_valid); end
    drive32(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    cyc();
    drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checks++; if (bus32.out_valid !== 1'b1) begin errors++; $display("FAIL add1_valid: got %b want 1", bus32.out_valid); end
    checks++; if ({bus32.ovf, bus32.cout, bus32.sum} !== {2'b00, 32'd2047}) begin errors++; $display("FAIL add1_result: got %b%b %h want 00 000007ff", bus32.ovf, bus32.cout, bus32.sum); end
    cyc();
    checks++; if (bus32.out_valid !== 1'b1) begin errors++; $display("FAIL add2_valid: got %b want 1", bus32.out_valid); end
    checks++; if ({bus32.ovf, bus32.cout, bus32.sum} !== {2'b01, 32'd0}) begin errors++; $display("FAIL add2_wrap: got %b%b %h want 01 00000000", bus32.ovf, bus32.cout, bus32.sum); end
    cyc();
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", bus32.out_valid); end
  endtask

  task automatic test_signed_overflow();
    settle32();
    drive32(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    cyc();
    drive32(1'b1, 32'd0, 32'd1, 1'b0, 1'b1);
    cyc();
    checks++; if ({bus32.out_valid, bus32.ovf, bus32.cout, bus32.sum} !== {3'b110, 32'h8000_0000}) begin errors++; $display("FAIL ovf_pos: got v%b o%b c%b %h want v1 o1 c0 80000000", bus32.out_valid, bus32.ovf, bus32.cout, bus32.sum); end
    drive32(1'b1, 32'd5, 32'd5, 1'b0, 1'b1);
    cyc();
    checks++; if ({bus32.out_valid, bus32.ovf, bus32.cout, bus32.sum} !== {3'b100, 32'hFFFF_FFFF}) begin errors++; $display("FAIL sub_borrow: got v%b o%b c%b %h want v1 o0 c0 ffffffff", bus32.out_valid, bus32.ovf, bus32.cout, bus32.sum); end
    drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    cyc();
    checks++; if ({bus32.out_valid, bus32.ovf, bus32.cout, bus32.sum} !== {3'b101, 32'd0}) begin errors++; $display("FAIL sub_equal: got v%b o%b c%b %h want v1 o0 c1 00000000", bus32.out_valid, bus32.ovf, bus32.cout, bus32.sum); end
  endtask

  task automatic test_sub_cin_ignored();
    settle32();
    drive32(1'b1, 32'd10, 32'd3, 1'b1, 1'b1);
    cyc();
    drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    cyc();
    checks++; if ({bus32.out_valid, bus32.ovf, bus32.cout, bus32.sum} !== {3'b101, 32'd7}) begin errors++; $display("FAIL sub_cin_ignored: got v%b o%b c%b %h want v1 o0 c1 00000007", bus32.out_valid, bus32.ovf, bus32.cout, bus32.sum); end
  endtask

  task automatic test_backpressure();
    settle32();
    bus32.out_ready = 1'b0;
    drive32(1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
    cyc();
    drive32(1'b1, 32'd2, 32'd2, 1'b0, 1'b0);
    cyc();
    drive32(1'b1, 32'd3, 32'd3, 1'b0, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus32.out_valid, bus32.in_ready, bus32.sum} !== {2'b10, 32'd2}) begin errors++; $display("FAIL stall_hold[%0d]: got v%b r%b sum %0d want v1 r0 sum 2", i, bus32.out_valid, bus32.in_ready, bus32.sum); end
      cyc();
    end
    bus32.out_ready = 1'b1;
    #1;
    checks++; if ({bus32.out_valid, bus32.in_ready, bus32.sum} !== {2'b11, 32'd2}) begin errors++; $display("FAIL release_first: got v%b r%b sum %0d want v1 r1 sum 2", bus32.out_valid, bus32.in_ready, bus32.sum); end
    cyc();
    drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checks++; if ({bus32.out_valid, bus32.sum} !== {1'b1, 32'd4}) begin errors++; $display("FAIL release_second: got v%b sum %0d want v1 sum 4", bus32.out_valid, bus32.sum); end
    cyc();
    checks++; if ({bus32.out_valid, bus32.sum} !== {1'b1, 32'd6}) begin errors++; $display("FAIL release_third: got v%b sum %0d want v1 sum 6", bus32.out_valid, bus32.sum); end
    cyc();
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL release_drain: got %b want 0", bus32.out_valid); end
  endtask

  task automatic test_reset_midflight();
    settle32();
    bus32.out_ready = 1'b0;
    drive32(1'b1, 32'd7, 32'd8, 1'b0, 1'b0);
    cyc();
    drive32(1'b1, 32'd9, 32'd1, 1'b0, 1'b0);
    cyc();
    drive32(1'b1, 32'd4, 32'd4, 1'b0, 1'b0);
    checks++; if ({bus32.out_valid, bus32.sum} !== {1'b1, 32'd15}) begin errors++; $display("FAIL flush_setup: got v%b sum %0d want v1 sum 15", bus32.out_valid, bus32.sum); end
    rst = 1'b1;
    #1;
    checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", bus32.in_ready); end
    cyc();
    checks++; if ({bus32.out_valid, bus32.ovf, bus32.cout, bus32.sum} !== {3'b000, 32'd0}) begin errors++; $display("FAIL flush_cleared: got v%b o%b c%b %h want all 0", bus32.out_valid, bus32.ovf, bus32.cout, bus32.sum); end
    rst = 1'b0;
    drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d]: got v%b sum %0d want v0", i, bus32.out_valid, bus32.sum); end
    end
  endtask

  task automatic test_exhaustive_w4();
    logic [5:0]  q[$];
    logic [65:0] r;
    logic [9:0]  v;
    logic [5:0]  want;
    int          seen;
    int          first;
    seen  = 0;
    first = -1;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      v = 10'(i);
      bus4.in_valid = 1'b1;
      bus4.a   = v[3:0];
      bus4.b   = v[7:4];
      bus4.cin = v[8];
      bus4.sub = v[9];
      r = model(4, {60'd0, v[3:0]}, {60'd0, v[7:4]}, v[8], v[9]);
      q.push_back({r[65], r[64], r[3:0]});
      cyc();
      if (bus4.out_valid) begin
        if (first < 0) first = i;
        want = (q.size() != 0) ? q.pop_front() : 6'bxxxxxx;
        seen++;
        checks++; if ({bus4.ovf, bus4.cout, bus4.sum} !== want) begin errors++; $display("FAIL w4_result[%0d]: got %b want %b", seen - 1, {bus4.ovf, bus4.cout, bus4.sum}, want); end
      end
    end
    bus4.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bus4.out_valid) begin
        want = (q.size() != 0) ? q.pop_front() : 6'bxxxxxx;
        seen++;
        checks++; if ({bus4.ovf, bus4.cout, bus4.sum} !== want) begin errors++; $display("FAIL w4_result[%0d]: got %b want %b", seen - 1, {bus4.ovf, bus4.cout, bus4.sum}, want); end
      end
    end
    checks++; if (first !== 2) begin errors++; $display("FAIL w4_latency: first result after beat %0d want 2", first); end
    checks++; if (seen !== 1024) begin errors++; $display("FAIL w4_count: got %0d want 1024", seen); end
  endtask

  task automatic test_random_w8();
    logic [9:0]  q[$];
    logic [65:0] r;
    logic [9:0]  want;
    logic [9:0]  hold_d;
    logic        hold_v;
    logic        have;
    logic        acc;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rc;
    logic        rs;
    int          sent;
    int          recv;
    hold_v = 1'b0;
    have   = 1'b0;
    sent   = 0;
    recv   = 0;
    ra = 8'd0; rb = 8'd0; rc = 1'b0; rs = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      if (!have && sent < 1500 && $urandom_range(0, 3) != 0) begin
        have = 1'b1;
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
      end
      bus8.in_valid  = have;
      bus8.a = ra; bus8.b = rb; bus8.cin = rc; bus8.sub = rs;
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (hold_v) begin
        checks++; if ({bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum} !== {1'b1, hold_d}) begin errors++; $display("FAIL w8_hold: got v%b %b want v1 %b", bus8.out_valid, {bus8.ovf, bus8.cout, bus8.sum}, hold_d); end
      end
      acc = bus8.in_valid && bus8.in_ready;
      if (bus8.out_valid && bus8.out_ready) begin
        want = (q.size() != 0) ? q.pop_front() : 10'bx;
        recv++;
        checks++; if ({bus8.ovf, bus8.cout, bus8.sum} !== want) begin errors++; $display("FAIL w8_result[%0d]: got %b want %b", recv - 1, {bus8.ovf, bus8.cout, bus8.sum}, want); end
      end
      hold_v = bus8.out_valid && !bus8.out_ready;
      hold_d = {bus8.ovf, bus8.cout, bus8.sum};
      cyc();
      if (acc) begin
        r = model(8, {56'd0, ra}, {56'd0, rb}, rc, rs);
        q.push_back({r[65], r[64], r[7:0]});
        have = 1'b0;
        sent++;
      end
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus8.out_valid) begin
        want = (q.size() != 0) ? q.pop_front() : 10'bx;
        recv++;
        checks++; if ({bus8.ovf, bus8.cout, bus8.sum} !== want) begin errors++; $display("FAIL w8_result[%0d]: got %b want %b", recv - 1, {bus8.ovf, bus8.cout, bus8.sum}, want); end
      end
      cyc();
    end
    checks++; if (recv !== sent || sent < 100) begin errors++; $display("FAIL w8_count: got %0d results want %0d (sent)", recv, sent); end
  endtask

  initial begin
    rst = 1'b1;
    drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus32.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = 4'd0; bus4.b = 4'd0; bus4.cin = 1'b0; bus4.sub = 1'b0; bus4.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0; bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.out_ready = 1'b1;
    test_reset();
    test_add_stream();
    test_signed_overflow();
    test_sub_cin_ignored();
    test_backpressure();
    test_reset_midflight();
    test_exhaustive_w4();
    test_random_w8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
